y86_dmem_arbiter: RTL and testbench

Sequences the shared single-port 64-bit word memory (8192 words) between the fetch read port and the memory-stage read/write port of the Y86 core. It grants one requester per transaction and tracks read latency. It also routes read data back to the owner, range-checks addresses (the same role as the existing adr_memory error flag), and raises a stall to the core while a request waits.

---
 rtl/y86_mem_pkg.sv | 39 +++
 rtl/mem_rsp_timer.sv | 79 +++++++
 rtl/y86_dmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_y86_dmem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_mem_pkg.sv
// y86_mem_pkg
// Shared definitions for the Y86 data-memory arbiter slice.
//   MEM_DEPTH / MEM_AW : size of the single-port 64-bit word memory
//   arb_state_t        : arbiter FSM states
//   owner_t            : which requester owns the outstanding transaction
//   I* constants       : icodes the upstream request generator decodes to pick
//                        read/write and address/data sources
//   addr_in_range()    : full-width range check so high address bits are never lost
package y86_mem_pkg;

  localparam int unsigned MEM_DEPTH = 8192;
  localparam int unsigned MEM_AW    = 13;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ERR_RSP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    OWN_IF = 2'd1,
    OWN_DM = 2'd2
  } owner_t;

  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Compare the whole 64-bit address; truncating first would alias
  // out-of-range addresses onto valid words.
  function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned depth);
    return addr < 64'(depth);
  endfunction

endpackage

// File: rtl/mem_rsp_timer.sv
// mem_rsp_timer
// Tracks the single outstanding memory transaction: a latency down-counter,
// the owner tag and the response kind. Emits a one-cycle rvalid pulse to
// the owner when the counter expires.
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : a transaction was granted this cycle
//   start_owner     : requester that received the grant
//   start_lat       : cycles from the grant to the response (1..7)
//   start_err       : the transaction is an out-of-range error response
//   start_rd        : the response carries memory read data
//   if_rvalid       : response pulse for fetch
//   dm_rvalid       : response pulse for the memory stage
//   rsp_err/rsp_rd  : kind of the response firing this cycle
//   rsp_fire        : any response fires this cycle
module mem_rsp_timer
  import y86_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  owner_t     start_owner,
  input  logic [2:0] start_lat,
  input  logic       start_err,
  input  logic       start_rd,
  output logic       if_rvalid,
  output logic       dm_rvalid,
  output logic       rsp_err,
  output logic       rsp_rd,
  output logic       rsp_fire
);

  logic [2:0] lat_cnt_q, lat_cnt_d;
  owner_t     owner_q, owner_d;
  logic       err_q, err_d;
  logic       rd_q, rd_d;

  // Gated by rst_n so nothing leaks out while reset is held.
  assign rsp_fire  = rst_n && (owner_q != NONE) && (lat_cnt_q == 3'd0);
  assign if_rvalid = rsp_fire && (owner_q == OWN_IF);
  assign dm_rvalid = rsp_fire && (owner_q == OWN_DM);
  assign rsp_err   = rsp_fire && err_q;
  assign rsp_rd    = rsp_fire && rd_q;

  // A new start in the same cycle a response fires replaces the finished
  // transaction; that is what makes back-to-back grants possible.
  always_comb begin
    lat_cnt_d = lat_cnt_q;
    owner_d   = owner_q;
    err_d     = err_q;
    rd_d      = rd_q;
    if ((owner_q != NONE) && (lat_cnt_q != 3'd0)) begin
      lat_cnt_d = lat_cnt_q - 3'd1;
    end
    if (rsp_fire) begin
      owner_d = NONE;
    end
    if (start) begin
      owner_d   = start_owner;
      lat_cnt_d = start_lat - 3'd1;
      err_d     = start_err;
      rd_d      = start_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_cnt_q <= 3'd0;
      owner_q   <= NONE;
      err_q     <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      lat_cnt_q <= lat_cnt_d;
      owner_q   <= owner_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
    end
  end

endmodule

// File: rtl/y86_dmem_arbiter.sv
// y86_dmem_arbiter
// Shares the single-port 64-bit word memory between the fetch read port and
// the memory-stage read/write port. One transaction is outstanding at a time.
//   clk, rst_n                     : clock, synchronous active-low reset
//   if_req/if_addr                 : fetch read request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata/if_err: fetch grant and response
//   dm_req/dm_we/dm_addr/dm_wdata  : memory-stage request (held until dm_gnt)
//   dm_gnt/dm_rvalid/dm_rdata/dm_err: memory-stage grant and response
//   mem_en/mem_we/mem_addr/mem_wdata: memory strobe, driven in the grant cycle
//   mem_rdata                      : memory data, valid RD_LAT cycles after mem_en
//   cpu_stall                      : some request is pending without a grant
module y86_dmem_arbiter #(
  parameter int unsigned MEM_DEPTH  = y86_mem_pkg::MEM_DEPTH,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [63:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [63:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [12:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        cpu_stall
);

  import y86_mem_pkg::*;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] RD_LAT_C   = 3'(RD_LAT);

  arb_state_t  state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;

  logic        can_grant;
  logic        fetch_wins;
  logic        grant_if;
  logic        grant_dm;
  logic        any_gnt;
  logic [63:0] sel_addr;
  logic        sel_we;
  logic        sel_in_range;
  owner_t      start_owner;
  logic [2:0]  start_lat;

  logic        rsp_fire;
  logic        rsp_err;
  logic        rsp_rd;
  logic        if_rv;
  logic        dm_rv;

  // A read response cycle hands the FSM back to IDLE immediately, so a
  // grant is allowed alongside it.
  assign can_grant = rst_n && ((state_q == IDLE) || ((state_q == RD_WAIT) && rsp_fire));

  // Memory stage normally wins; fetch wins once it has watched STARVE_MAX
  // consecutive dm grants go by.
  always_comb begin
    fetch_wins   = if_req && (!dm_req || (starve_cnt_q == STARVE_LIM));
    grant_if     = can_grant && fetch_wins;
    grant_dm     = can_grant && dm_req && !fetch_wins;
    any_gnt      = grant_if || grant_dm;
    sel_addr     = grant_if ? if_addr : dm_addr;
    sel_we       = grant_dm && dm_we;
    sel_in_range = addr_in_range(sel_addr, MEM_DEPTH);
    start_owner  = grant_if ? OWN_IF : OWN_DM;
    start_lat    = (sel_in_range && !sel_we) ? RD_LAT_C : 3'd1;
  end

  assign if_gnt    = grant_if;
  assign dm_gnt    = grant_dm;
  assign mem_en    = any_gnt && sel_in_range;
  assign mem_we    = mem_en && sel_we;
  assign mem_addr  = any_gnt ? sel_addr[MEM_AW-1:0] : '0;
  assign mem_wdata = mem_we ? dm_wdata : '0;
  assign cpu_stall = rst_n && ((if_req && !grant_if) || (dm_req && !grant_dm));

  // Writes complete without leaving IDLE; reads wait for data; an
  // out-of-range access spends one cycle in ERR_RSP delivering the error.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      RD_WAIT: if (rsp_fire) state_d = IDLE;
      ERR_RSP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (any_gnt) begin
      if (!sel_in_range) begin
        state_d = ERR_RSP;
      end else if (sel_we) begin
        state_d = IDLE;
      end else begin
        state_d = RD_WAIT;
      end
    end
  end

  // Counts dm grants that fetch has been passed over for.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || grant_if) begin
      starve_cnt_d = 4'd0;
    end else if (grant_dm) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  mem_rsp_timer u_rsp_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (any_gnt),
    .start_owner (start_owner),
    .start_lat   (start_lat),
    .start_err   (!sel_in_range),
    .start_rd    (sel_in_range && !sel_we),
    .if_rvalid   (if_rv),
    .dm_rvalid   (dm_rv),
    .rsp_err     (rsp_err),
    .rsp_rd      (rsp_rd),
    .rsp_fire    (rsp_fire)
  );

  // Read data passes straight through from memory; writes and errors return 0.
  assign if_rvalid = if_rv;
  assign dm_rvalid = dm_rv;
  assign if_rdata  = (if_rv && rsp_rd) ? mem_rdata : '0;
  assign dm_rdata  = (dm_rv && rsp_rd) ? mem_rdata : '0;
  assign if_err    = if_rv && rsp_err;
  assign dm_err    = dm_rv && rsp_err;

endmodule

// File: tb/tb_y86_dmem_arbiter.sv
// tb_y86_dmem_arbiter
// Drives fetch and memory-stage requests, models the memory with RD_LAT
// read latency, and checks grants, memory strobes, stall and responses
// against a cycle model plus per-requester expected-response queues.
module tb_y86_dmem_arbiter;

  localparam int RD_LAT = 2;
  localparam int DEPTH  = 8192;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [63:0] if_rdata;
  logic        if_err;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [63:0] dm_rdata;
  logic        dm_err;
  logic        mem_en;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        cpu_stall;

  y86_dmem_arbiter #(
    .MEM_DEPTH  (DEPTH),
    .RD_LAT     (RD_LAT),
    .STARVE_MAX (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .dm_err    (dm_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .cpu_stall (cpu_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s got=%h expected=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Memory model: writes land at the clock edge, read data walks a
  // RD_LAT-deep pipe so it appears RD_LAT cycles after the mem_en cycle.
  logic [63:0] mem [DEPTH];
  logic [63:0] pipe [RD_LAT];
  logic        loaded = 1'b0;

  assign mem_rdata = pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 64'hA5A5_0000_0000_0000 | 64'(i);
      mem[5] <= 64'hDEAD_BEEF;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      loaded <= 1'b1;
    end else begin
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      for (int i = RD_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  // Scoreboard state: expected responses {err, data} per requester, the
  // bench's own copy of memory contents, and a cycle-level arbiter model.
  logic [64:0] if_q [$];
  logic [64:0] dm_q [$];
  logic [63:0] ref_mem [DEPTH];
  int          cyc      = 0;
  int          free_cyc = 0;
  int          starve   = 0;
  int          if_due   = -1;
  int          dm_due   = -1;
  bit          if_pend  = 0;
  bit          dm_pend  = 0;
  bit          log_en   = 0;
  logic [63:0] hist     = '0;
  int          hist_n   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Cycle monitor, sampled mid-cycle on the falling edge.
  logic        exp_if_g, exp_dm_g, g_we, g_rng;
  logic [63:0] g_addr;
  logic [64:0] e;
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_quiet", 64'(|{if_gnt, if_rvalid, if_rdata, if_err, dm_gnt, dm_rvalid, dm_rdata,
                                     dm_err, mem_en, mem_we, mem_addr, mem_wdata, cpu_stall}), 64'd0);
      free_cyc = cyc + 1;
      starve   = 0;
      if_due   = -1;
      dm_due   = -1;
      if_pend  = 0;
      dm_pend  = 0;
      if_q.delete();
      dm_q.delete();
    end else begin
      if (if_pend) checkOutput("if_req_held", 64'(if_req), 64'd1);
      if (dm_pend) checkOutput("dm_req_held", 64'(dm_req), 64'd1);

      if (if_rvalid || cyc == if_due) begin
        checkOutput("if_rvalid", 64'(if_rvalid), 64'd1);
        checkOutput("if_rsp_cycle", 64'(cyc), 64'(if_due));
        if (if_q.size() == 0) checkOutput("if_rsp_expected", 64'd0, 64'd1);
        else begin
          e = if_q.pop_front();
          checkOutput("if_rdata", if_rdata, e[63:0]);
          checkOutput("if_err", 64'(if_err), 64'(e[64]));
        end
        if_due = -1;
      end
      if (dm_rvalid || cyc == dm_due) begin
        checkOutput("dm_rvalid", 64'(dm_rvalid), 64'd1);
        checkOutput("dm_rsp_cycle", 64'(cyc), 64'(dm_due));
        if (dm_q.size() == 0) checkOutput("dm_rsp_expected", 64'd0, 64'd1);
        else begin
          e = dm_q.pop_front();
          checkOutput("dm_rdata", dm_rdata, e[63:0]);
          checkOutput("dm_err", 64'(dm_err), 64'(e[64]));
        end
        dm_due = -1;
      end

      exp_if_g = (cyc >= free_cyc) && if_req && (!dm_req || starve == 2);
      exp_dm_g = (cyc >= free_cyc) && dm_req && !exp_if_g;
      checkOutput("if_gnt", 64'(if_gnt), 64'(exp_if_g));
      checkOutput("dm_gnt", 64'(dm_gnt), 64'(exp_dm_g));
      checkOutput("cpu_stall", 64'(cpu_stall), 64'((if_req && !exp_if_g) || (dm_req && !exp_dm_g)));

      if (exp_if_g || exp_dm_g) begin
        g_addr = exp_if_g ? if_addr : dm_addr;
        g_we   = exp_dm_g && dm_we;
        g_rng  = g_addr < 64'(DEPTH);
        checkOutput("mem_en", 64'(mem_en), 64'(g_rng));
        checkOutput("mem_we", 64'(mem_we), 64'(g_rng && g_we));
        checkOutput("mem_addr", 64'(mem_addr), 64'(g_addr[12:0]));
        checkOutput("mem_wdata", mem_wdata, (g_rng && g_we) ? dm_wdata : 64'd0);
        if (exp_if_g) if_due = cyc + ((g_rng && !g_we) ? RD_LAT : 1);
        else          dm_due = cyc + ((g_rng && !g_we) ? RD_LAT : 1);
        free_cyc = cyc + (g_rng ? (g_we ? 1 : RD_LAT) : 2);
      end else begin
        checkOutput("mem_idle", 64'({mem_en, mem_we}), 64'd0);
      end

      if (!if_req || exp_if_g) starve = 0;
      else if (exp_dm_g) starve = starve + 1;

      if (log_en && (if_gnt || dm_gnt)) begin
        hist   = {hist[62:0], if_gnt};
        hist_n = hist_n + 1;
      end

      if_pend = if_req && !if_gnt;
      dm_pend = dm_req && !dm_gnt;
    end
  end

  // Raise a request, queue its expected response, and hold it until granted.
  task automatic applyStimulus(input bit is_dm, input bit we, input logic [63:0] addr,
                               input logic [63:0] wdata);
    logic [64:0] rsp;
    bit          got;
    @(posedge clk);
    #1;
    if (addr >= 64'(DEPTH))  rsp = {1'b1, 64'd0};
    else if (is_dm && we)    rsp = {1'b0, 64'd0};
    else                     rsp = {1'b0, ref_mem[addr[12:0]]};
    if (is_dm && we && addr < 64'(DEPTH)) ref_mem[addr[12:0]] = wdata;
    if (is_dm) begin
      dm_req   = 1'b1;
      dm_we    = we;
      dm_addr  = addr;
      dm_wdata = wdata;
      dm_q.push_back(rsp);
    end else begin
      if_req  = 1'b1;
      if_addr = addr;
      if_q.push_back(rsp);
    end
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = is_dm ? dm_gnt : if_gnt;
    end
    if (!got) checkOutput(is_dm ? "dm_gnt_timeout" : "if_gnt_timeout", 64'd0, 64'd1);
  endtask

  task automatic dropReq(input bit is_dm);
    @(posedge clk);
    #1;
    if (is_dm) dm_req = 1'b0;
    else       if_req = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    ref_mem[5] = 64'hDEAD_BEEF;
    idleCycles(3);
    #1 rst_n = 1'b1;

    $display("[TB] dm read of a preloaded word");
    applyStimulus(1, 0, 64'd5, 64'd0);
    dropReq(1);
    idleCycles(4);

    $display("[TB] dm write then fetch read of the same word");
    applyStimulus(1, 1, 64'd100, 64'h1234);
    dropReq(1);
    applyStimulus(0, 0, 64'd100, 64'd0);
    dropReq(0);
    idleCycles(4);

    $display("[TB] both requesters held: starvation limit");
    log_en = 1;
    fork
      begin
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 64'($urandom_range(0, 4095)), 64'd0);
        dropReq(0);
      end
      begin
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 64'($urandom_range(0, DEPTH - 1)), 64'd0);
        dropReq(1);
      end
    join
    log_en = 0;
    checkOutput("grant_order", hist & 64'h1FF, 64'b001001001);
    checkOutput("grant_count", 64'(hist_n), 64'd9);
    idleCycles(4);

    $display("[TB] out-of-range dm reads");
    applyStimulus(1, 0, 64'd8192, 64'd0);
    applyStimulus(1, 0, 64'h1_0000_0005, 64'd0);
    dropReq(1);
    idleCycles(4);

    $display("[TB] reset with a fetch read in flight");
    applyStimulus(0, 0, 64'd7, 64'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    if_req  = 1'b1;
    if_addr = 64'd9;
    dm_req  = 1'b1;
    dm_addr = 64'd3;
    idleCycles(2);
    #1;
    if_req = 1'b0;
    dm_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idleCycles(5);
    applyStimulus(1, 0, 64'd5, 64'd0);
    dropReq(1);
    idleCycles(4);

    $display("[TB] back-to-back fetch reads");
    applyStimulus(0, 0, 64'd1, 64'd0);
    applyStimulus(0, 0, 64'd2, 64'd0);
    applyStimulus(0, 0, 64'd3, 64'd0);
    dropReq(0);
    idleCycles(4);

    $display("[TB] mixed random traffic");
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          applyStimulus(0, 0, ($urandom_range(0, 9) == 0) ? 64'd9000 : 64'($urandom_range(0, 4095)), 64'd0);
          if ($urandom_range(0, 1) == 1) dropReq(0);
        end
        dropReq(0);
      end
      begin
        for (int i = 0; i < 20; i++) begin
          if ($urandom_range(0, 9) == 0)
            applyStimulus(1, 0, {32'h0000_0001, 32'($urandom)}, 64'd0);
          else if ($urandom_range(0, 1) == 1)
            applyStimulus(1, 1, 64'($urandom_range(4096, DEPTH - 1)), {32'($urandom), 32'($urandom)});
          else
            applyStimulus(1, 0, 64'($urandom_range(0, DEPTH - 1)), 64'd0);
          if ($urandom_range(0, 1) == 1) dropReq(1);
        end
        dropReq(1);
      end
    join
    idleCycles(10);

    checkOutput("if_q_drained", 64'(if_q.size()), 64'd0);
    checkOutput("dm_q_drained", 64'(dm_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
